// File: rtl/psram_pkg.sv
// Shared widths, FSM states, bus payload and lane helpers for the Wishbone-to-FML PSRAM bridge.
package psram_pkg;

  localparam int unsigned FML_ADR_W  = 23;
  localparam int unsigned WB_ADR_W   = 32;
  localparam int unsigned WB_DAT_W   = 32;
  localparam int unsigned WB_SEL_W   = 4;
  localparam int unsigned LINE_W     = 64;
  localparam int unsigned LINE_SEL_W = 8;
  localparam int unsigned TAG_LSB    = 3;
  localparam int unsigned TAG_MSB    = 23;
  localparam int unsigned TAG_W      = TAG_MSB - TAG_LSB + 1;
  localparam int unsigned LANE_BIT   = 2;

  localparam logic [LINE_SEL_W-1:0] SEL_LO_MASK = 8'h0F;
  localparam logic [LINE_SEL_W-1:0] SEL_HI_MASK = 8'hF0;

  typedef enum logic [1:0] {
    WAIT_RDY = 2'd0,
    IDLE     = 2'd1,
    REQ      = 2'd2,
    ACK      = 2'd3
  } state_t;

  typedef struct packed {
    logic [FML_ADR_W-1:0]  adr;
    logic                  we;
    logic [LINE_SEL_W-1:0] sel;
    logic [LINE_W-1:0]     dat;
  } fml_req_t;

  // Place 4 Wishbone byte enables on the addressed half of the 8-byte line.
  function automatic logic [LINE_SEL_W-1:0] lane_sel(input logic hi, input logic [WB_SEL_W-1:0] sel);
    return {sel, sel} & (hi ? SEL_HI_MASK : SEL_LO_MASK);
  endfunction

  function automatic logic [WB_DAT_W-1:0] lane_data(input logic hi, input logic [LINE_W-1:0] line);
    return hi ? line[LINE_W-1:WB_DAT_W] : line[WB_DAT_W-1:0];
  endfunction

endpackage

// File: rtl/psram_wb_bridge_if.sv
// Wishbone classic slave bus bundle for the PSRAM bridge.
interface psram_wb_bridge_if;
  import psram_pkg::*;

  logic [WB_ADR_W-1:0] wb_adr_i;
  logic [WB_DAT_W-1:0] wb_dat_i;
  logic [WB_DAT_W-1:0] wb_dat_o;
  logic [WB_SEL_W-1:0] wb_sel_i;
  logic                wb_cyc_i;
  logic                wb_stb_i;
  logic                wb_we_i;
  logic                wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/psram_line_cache.sv
// One-line write-through read cache: tag, valid, byte-merged data and hit compare.
module psram_line_cache
  import psram_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [TAG_W-1:0]      lookup_tag,
  input  logic                  upd_en,
  input  logic                  upd_we,
  input  logic [TAG_W-1:0]      upd_tag,
  input  logic [LINE_SEL_W-1:0] upd_sel,
  input  logic [LINE_W-1:0]     upd_data,
  output logic                  hit_c,
  output logic [LINE_W-1:0]     line_data
);

  logic             valid_q;
  logic [TAG_W-1:0] tag_q;

  // Read completion refills the line; a write to the held line merges its enabled bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      tag_q     <= '0;
      line_data <= '0;
    end else if (upd_en) begin
      if (!upd_we) begin
        valid_q   <= 1'b1;
        tag_q     <= upd_tag;
        line_data <= upd_data;
      end else if (valid_q && (tag_q == upd_tag)) begin
        for (int b = 0; b < int'(LINE_SEL_W); b++) begin
          if (upd_sel[b]) line_data[8*b +: 8] <= upd_data[8*b +: 8];
        end
      end
    end
  end

  assign hit_c = valid_q && (tag_q == lookup_tag);

endmodule

// File: rtl/psram_wb_bridge.sv
// Wishbone classic slave to 64-bit FML master bridge for the PSRAM controller.
// Optional one-line read cache enabled by defining PSRAM_WB_BRIDGE_CACHE_EN.
module psram_wb_bridge
  import psram_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  controller_ready,
  psram_wb_bridge_if.slave      wb,
  output logic [FML_ADR_W-1:0]  fml_adr,
  output logic                  fml_stb,
  output logic                  fml_we,
  output logic [LINE_SEL_W-1:0] fml_sel,
  output logic [LINE_W-1:0]     fml_do,
  input  logic [LINE_W-1:0]     fml_di,
  input  logic                  fml_eack
);

  state_t              state_q, state_d;
  fml_req_t            fml_q, fml_d;
  logic                fml_stb_d;
  logic                hi_q, hi_d;
  logic                we_q, we_d;
  logic                abort_q, abort_d;
  logic                ack_d;
  logic [WB_DAT_W-1:0] dat_d;

  logic                cyc_stb_c;
  logic                abort_c;
  logic                hit_c;
  logic [LINE_W-1:0]   cache_line;
  logic [TAG_W-1:0]    lookup_tag;
  logic                unused_adr;

  assign cyc_stb_c  = wb.wb_cyc_i & wb.wb_stb_i;
  assign abort_c    = abort_q | ~wb.wb_cyc_i;
  assign lookup_tag = wb.wb_adr_i[TAG_MSB:TAG_LSB];
  assign unused_adr = ^{wb.wb_adr_i[WB_ADR_W-1:TAG_MSB+1], wb.wb_adr_i[1:0]};

`ifdef PSRAM_WB_BRIDGE_CACHE_EN
  logic upd_en_c;
  assign upd_en_c = (state_q == REQ) && fml_eack;

  psram_line_cache u_cache (
    .clk        (clk),
    .rst_n      (rst_n),
    .lookup_tag (lookup_tag),
    .upd_en     (upd_en_c),
    .upd_we     (fml_q.we),
    .upd_tag    (fml_q.adr[FML_ADR_W-1:2]),
    .upd_sel    (fml_q.sel),
    .upd_data   (fml_q.we ? fml_q.dat : fml_di),
    .hit_c      (hit_c),
    .line_data  (cache_line)
  );
`else
  assign hit_c      = 1'b0;
  assign cache_line = '0;
`endif

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_RDY;
      fml_q       <= '0;
      fml_stb     <= 1'b0;
      hi_q        <= 1'b0;
      we_q        <= 1'b0;
      abort_q     <= 1'b0;
      wb.wb_ack_o <= 1'b0;
      wb.wb_dat_o <= '0;
    end else begin
      state_q     <= state_d;
      fml_q       <= fml_d;
      fml_stb     <= fml_stb_d;
      hi_q        <= hi_d;
      we_q        <= we_d;
      abort_q     <= abort_d;
      wb.wb_ack_o <= ack_d;
      wb.wb_dat_o <= dat_d;
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_RDY: if (controller_ready) state_d = IDLE;
      IDLE:     if (cyc_stb_c) state_d = (!wb.wb_we_i && hit_c) ? ACK : REQ;
      REQ:      if (fml_eack) state_d = abort_c ? IDLE : ACK;
      ACK:      state_d = IDLE;
      default:  state_d = WAIT_RDY;
    endcase
  end

  // Next values of the registered outputs; the FML request stays frozen throughout REQ.
  always_comb begin
    fml_d     = fml_q;
    fml_stb_d = fml_stb;
    hi_d      = hi_q;
    we_d      = we_q;
    abort_d   = abort_q;
    ack_d     = 1'b0;
    dat_d     = wb.wb_dat_o;
    case (state_q)
      IDLE: begin
        if (cyc_stb_c) begin
          hi_d    = wb.wb_adr_i[LANE_BIT];
          we_d    = wb.wb_we_i;
          abort_d = 1'b0;
          if (!wb.wb_we_i && hit_c) begin
            ack_d = 1'b1;
            dat_d = lane_data(wb.wb_adr_i[LANE_BIT], cache_line);
          end else begin
            fml_stb_d = 1'b1;
            fml_d.adr = {lookup_tag, 2'b00};
            fml_d.we  = wb.wb_we_i;
            fml_d.sel = lane_sel(wb.wb_adr_i[LANE_BIT], wb.wb_sel_i);
            fml_d.dat = {wb.wb_dat_i, wb.wb_dat_i};
          end
        end
      end
      REQ: begin
        if (!wb.wb_cyc_i) abort_d = 1'b1;
        if (fml_eack) begin
          fml_stb_d = 1'b0;
          if (!abort_c) begin
            ack_d = 1'b1;
            if (!we_q) dat_d = lane_data(hi_q, fml_di);
          end
        end
      end
      default: ;
    endcase
  end

  assign fml_adr = fml_q.adr;
  assign fml_we  = fml_q.we;
  assign fml_sel = fml_q.sel;
  assign fml_do  = fml_q.dat;

endmodule

// File: tb/tb_psram_wb_bridge.sv
// Randomized self-checking bench for psram_wb_bridge with a byte-array memory reference model.
module tb_psram_wb_bridge;
  import psram_pkg::*;

`ifdef PSRAM_WB_BRIDGE_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif
  localparam int LAT_RD = 12;
  localparam int LAT_WR = 11;

  logic        clk;
  logic        rst_n;
  logic        controller_ready;
  logic [22:0] fml_adr;
  logic        fml_stb;
  logic        fml_we;
  logic [7:0]  fml_sel;
  logic [63:0] fml_do;
  logic [63:0] fml_di;
  logic        fml_eack;

  psram_wb_bridge_if wb ();

  psram_wb_bridge dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .controller_ready (controller_ready),
    .wb               (wb),
    .fml_adr          (fml_adr),
    .fml_stb          (fml_stb),
    .fml_we           (fml_we),
    .fml_sel          (fml_sel),
    .fml_do           (fml_do),
    .fml_di           (fml_di),
    .fml_eack         (fml_eack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // PSRAM device behind the controller: 16 lines of 64 bits.
  logic [63:0] dev_mem [16];
  int          n_req = 0;
  int          cnt   = 0;
  bit          busy  = 0;

  initial begin
    fml_eack = 1'b0;
    fml_di   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || fml_eack) begin
        fml_eack = 1'b0;
        cnt      = 0;
        busy     = 0;
      end else if (fml_stb) begin
        if (!busy) begin
          busy = 1;
          n_req++;
        end
        if (cnt == (fml_we ? LAT_WR : LAT_RD)) begin
          fml_eack = 1'b1;
          fml_di   = dev_mem[int'(fml_adr[5:2])];
          if (fml_we)
            for (int b = 0; b < 8; b++)
              if (fml_sel[b]) dev_mem[int'(fml_adr[5:2])][8*b +: 8] = fml_do[8*b +: 8];
        end else begin
          cnt++;
        end
      end
    end
  end

  // Reference model: byte-addressed memory plus which line the cache should hold.
  logic [7:0] ref_mem [128];
  bit         ref_valid = 0;
  int         ref_line  = 0;

  task automatic wb_idle();
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    wb.wb_we_i  = 1'b0;
  endtask

  task automatic wb_xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdat,
                         output int ack_at, output int eack_at, output int nreq);
    logic [22:0] s_adr;
    logic        s_we;
    logic [7:0]  s_sel;
    logic [63:0] s_do;
    logic [7:0]  exp_sel;
    bit          snapped;
    bit          hold_ok;
    int          req0;
    snapped = 0;
    hold_ok = 1;
    ack_at  = -1;
    eack_at = -1;
    rdat    = '0;
    exp_sel = 8'(sel) << (adr[2] ? 4 : 0);
    @(negedge clk);
    wb.wb_adr_i = adr;
    wb.wb_dat_i = dat;
    wb.wb_sel_i = sel;
    wb.wb_we_i  = we;
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    req0 = n_req;
    @(posedge clk);
    for (int k = 0; k < 100; k++) begin
      #1;
      if (fml_stb) begin
        if (!snapped) begin
          s_adr = fml_adr; s_we = fml_we; s_sel = fml_sel; s_do = fml_do;
          snapped = 1;
        end else if ({fml_adr, fml_we, fml_sel, fml_do} !== {s_adr, s_we, s_sel, s_do}) begin
          hold_ok = 0;
        end
      end
      if (fml_eack && eack_at < 0) eack_at = k;
      if (wb.wb_ack_o) begin
        ack_at = k + 1;
        rdat   = wb.wb_dat_o;
        break;
      end
      @(posedge clk);
    end
    check_eq("ack_seen", 64'(ack_at >= 0), 64'(1));
    if (snapped) begin
      check_eq("stb_low_after_eack", 64'(fml_stb), 64'(0));
      check_eq("fml_hold", 64'(hold_ok), 64'(1));
      check_eq("fml_adr", 64'(s_adr), 64'({adr[23:3], 2'b00}));
      check_eq("fml_we", 64'(s_we), 64'(we));
      if (we) begin
        check_eq("fml_sel", 64'(s_sel), 64'(exp_sel));
        check_eq("fml_do", s_do, {dat, dat});
      end
    end
    @(negedge clk);
    wb_idle();
    @(posedge clk);
    #1;
    check_eq("ack_one_cycle", 64'(wb.wb_ack_o), 64'(0));
    nreq = n_req - req0;
  endtask

  task automatic do_xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdat);
    int          line, base, ack_at, eack_at, nreq;
    bit          hit;
    logic [31:0] exp;
    line = int'(adr[6:3]);
    base = int'({adr[6:2], 2'b00});
    hit  = CACHE_EN && ref_valid && (ref_line == line);
    exp  = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
    wb_xfer(we, adr, dat, sel, rdat, ack_at, eack_at, nreq);
    if (we) begin
      check_eq("wr_nreq", 64'(nreq), 64'(1));
      check_eq("wr_eack_at", 64'(eack_at), 64'(LAT_WR + 1));
      check_eq("wr_ack_at", 64'(ack_at), 64'(LAT_WR + 2));
      for (int b = 0; b < 4; b++)
        if (sel[b]) ref_mem[base+b] = dat[8*b +: 8];
    end else if (hit) begin
      check_eq("hit_nreq", 64'(nreq), 64'(0));
      check_eq("hit_ack_at", 64'(ack_at), 64'(1));
      check_eq("hit_data", 64'(rdat), 64'(exp));
    end else begin
      check_eq("rd_nreq", 64'(nreq), 64'(1));
      check_eq("rd_eack_at", 64'(eack_at), 64'(LAT_RD + 1));
      check_eq("rd_ack_at", 64'(ack_at), 64'(LAT_RD + 2));
      check_eq("rd_data", 64'(rdat), 64'(exp));
      ref_valid = 1;
      ref_line  = line;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_fml_ctl"}, 64'({fml_stb, fml_we}), 64'(0));
    check_eq({tag, "_fml_sel"}, 64'(fml_sel), 64'(0));
    check_eq({tag, "_fml_adr"}, 64'(fml_adr), 64'(0));
    check_eq({tag, "_fml_do"}, fml_do, 64'(0));
    check_eq({tag, "_wb_ack"}, 64'(wb.wb_ack_o), 64'(0));
    check_eq({tag, "_wb_dat"}, 64'(wb.wb_dat_o), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rdat;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    bit          we, seen_stb, seen_ack, held, got_eack;
    int          line;

    for (int i = 0; i < 16; i++) dev_mem[i] = {$urandom, $urandom};
    dev_mem[3] = 64'h1122_3344_5566_7788;
    for (int i = 0; i < 16; i++)
      for (int b = 0; b < 8; b++) ref_mem[i*8+b] = dev_mem[i][8*b +: 8];

    wb_idle();
    wb.wb_adr_i = '0;
    wb.wb_dat_i = '0;
    wb.wb_sel_i = '0;
    controller_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Request pending while the controller is not ready must not reach FML.
    wb.wb_adr_i = 32'h0000_0018;
    wb.wb_sel_i = 4'hF;
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    seen_stb = 0;
    seen_ack = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (fml_stb) seen_stb = 1;
      if (wb.wb_ack_o) seen_ack = 1;
    end
    check_eq("no_stb_not_ready", 64'(seen_stb), 64'(0));
    check_eq("no_ack_not_ready", 64'(seen_ack), 64'(0));
    @(negedge clk);
    wb_idle();
    controller_ready = 1'b1;
    repeat (2) @(posedge clk);

    do_xfer(1'b1, 32'h0000_0010, 32'hA5A5_1234, 4'b0011, rdat);
    do_xfer(1'b0, 32'h0000_001C, 32'h0, 4'hF, rdat);
    check_eq("read_1c_const", 64'(rdat), 64'(32'h1122_3344));
    do_xfer(1'b0, 32'h0000_0018, 32'h0, 4'hF, rdat);
    check_eq("read_18_const", 64'(rdat), 64'(32'h5566_7788));
    do_xfer(1'b1, 32'h0000_0018, 32'hFFFF_FFFF, 4'b1000, rdat);
    do_xfer(1'b0, 32'h0000_0018, 32'h0, 4'hF, rdat);
    check_eq("merge_read_const", 64'(rdat), 64'(32'hFF66_7788));

    // Master abandons the cycle two cycles into REQ.
    @(negedge clk);
    wb.wb_adr_i = 32'h0000_0028;
    wb.wb_sel_i = 4'hF;
    wb.wb_we_i  = 1'b0;
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    @(posedge clk);
    held = 1;
    seen_ack = 0;
    got_eack = 0;
    repeat (2) begin
      #1;
      if (!fml_stb) held = 0;
      @(posedge clk);
    end
    @(negedge clk);
    wb_idle();
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (wb.wb_ack_o) seen_ack = 1;
      if (fml_eack) begin
        got_eack = 1;
        check_eq("abort_stb_clear", 64'(fml_stb), 64'(0));
        break;
      end else if (!fml_stb) begin
        held = 0;
      end
    end
    repeat (4) begin
      @(posedge clk);
      #1;
      if (wb.wb_ack_o) seen_ack = 1;
    end
    check_eq("abort_eack_seen", 64'(got_eack), 64'(1));
    check_eq("abort_stb_held", 64'(held), 64'(1));
    check_eq("abort_no_ack", 64'(seen_ack), 64'(0));
    ref_valid = 0;
    do_xfer(1'b0, 32'h0000_0030, 32'h0, 4'hF, rdat);

    // Asynchronous reset in the middle of a write to the cached line.
    @(negedge clk);
    wb.wb_adr_i = 32'h0000_0030;
    wb.wb_dat_i = 32'hDEAD_BEEF;
    wb.wb_sel_i = 4'hF;
    wb.wb_we_i  = 1'b1;
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #3;
    check_eq("stb_before_reset", 64'(fml_stb), 64'(1));
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_req_reset");
    wb_idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ref_valid = 0;
    do_xfer(1'b0, 32'h0000_0030, 32'h0, 4'hF, rdat);

    for (int i = 0; i < 80; i++) begin
      we   = 1'($urandom_range(0, 1));
      line = $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 15);
      adr  = {8'($urandom), 17'b0, 4'(line), 1'($urandom_range(0, 1)), 2'($urandom)};
      dat  = $urandom;
      sel  = we ? 4'($urandom_range(1, 15)) : 4'($urandom);
      do_xfer(we, adr, dat, sel, rdat);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
